// File: rtl/hmc_rf_regbank.sv
// Parametrised host register-file slave with RW, RO and W1C registers.
// Latency: a request accepted in cycle T completes in cycle T+1+ACCESS_LAT.
// Backpressure: rf_busy is high from T+1 through the completion cycle, and requests seen while busy are dropped.
//
// Ports:
//   clk_hmc, res_n_hmc        clock and synchronous active-low reset
//   rf_address/_read_en/_write_en/_write_data   request side, captured on acceptance
//   rf_read_data, rf_access_complete, rf_invalid_address, rf_busy   response side (registered)
//   hw_ro_in   per-register values returned by RO registers
//   hw_set     per-bit set strobes for W1C registers (applied every cycle)
//   hw_reg_out current register contents (RO slices read as 0)
module hmc_rf_regbank #(
    parameter int                  ADDR_W     = 4,
    parameter int                  DATA_W     = 64,
    parameter int                  NUM_REGS   = 12,
    parameter int                  ACCESS_LAT = 1,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0,
    parameter logic [NUM_REGS-1:0] W1C_MASK   = '0
) (
    input  logic                       clk_hmc,
    input  logic                       res_n_hmc,
    input  logic [ADDR_W-1:0]          rf_address,
    input  logic                       rf_read_en,
    input  logic                       rf_write_en,
    input  logic [DATA_W-1:0]          rf_write_data,
    output logic [DATA_W-1:0]          rf_read_data,
    output logic                       rf_access_complete,
    output logic                       rf_invalid_address,
    output logic                       rf_busy,
    input  logic [NUM_REGS*DATA_W-1:0] hw_ro_in,
    input  logic [NUM_REGS*DATA_W-1:0] hw_set,
    output logic [NUM_REGS*DATA_W-1:0] hw_reg_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // RO wins over W1C when both mask bits are set.
    localparam logic [NUM_REGS-1:0] W1C_EFF = W1C_MASK & ~RO_MASK;
    localparam logic [3:0]          LAT_M1  = (ACCESS_LAT > 0) ? 4'(ACCESS_LAT - 1) : 4'd0;
    localparam logic [ADDR_W:0]     NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

    state_t                           state_q, state_d;
    logic [3:0]                       cnt_q, cnt_d;
    logic [ADDR_W-1:0]                addr_q, addr_d;
    logic [DATA_W-1:0]                wdata_q, wdata_d;
    logic                             is_wr_q, is_wr_d;
    logic                             inv_q, inv_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]  regs_q, regs_d;
    logic [DATA_W-1:0]                rf_read_data_q, rf_read_data_d;
    logic                             rf_access_complete_q, rf_access_complete_d;
    logic                             rf_invalid_address_q, rf_invalid_address_d;
    logic                             rf_busy_q, rf_busy_d;
    logic [DATA_W-1:0]                rd_mux;

    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
        addr_d               = addr_q;
        wdata_d              = wdata_q;
        is_wr_d              = is_wr_q;
        inv_d                = inv_q;
        rf_read_data_d       = rf_read_data_q;
        rf_invalid_address_d = rf_invalid_address_q;
        rd_mux               = '0;

        // Background update: W1C registers accumulate hardware set strobes,
        // RO registers hold no state of their own.
        for (int i = 0; i < NUM_REGS; i++) begin
            if (RO_MASK[i]) begin
                regs_d[i] = '0;
            end else if (W1C_EFF[i]) begin
                regs_d[i] = regs_q[i] | hw_set[i*DATA_W +: DATA_W];
            end else begin
                regs_d[i] = regs_q[i];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (rf_read_en || rf_write_en) begin
                    addr_d  = rf_address;
                    wdata_d = rf_write_data;
                    is_wr_d = rf_write_en;
                    inv_d   = (rf_read_en && rf_write_en) || ({1'b0, rf_address} >= NUM_REGS_A);
                    cnt_d   = LAT_M1;
                    state_d = (ACCESS_LAT > 0) ? ST_WAIT : ST_DONE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                // Commit the write at the end of DONE so it shows up the cycle after.
                // The hardware set is OR-ed in last so it wins over a software clear.
                if (is_wr_q && !inv_q) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (addr_q == ADDR_W'(i) && !RO_MASK[i]) begin
                            if (W1C_EFF[i]) begin
                                regs_d[i] = (regs_q[i] & ~wdata_q) | hw_set[i*DATA_W +: DATA_W];
                            end else begin
                                regs_d[i] = wdata_q;
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_d == ADDR_W'(i)) begin
                rd_mux = RO_MASK[i] ? hw_ro_in[i*DATA_W +: DATA_W] : regs_q[i];
            end
        end

        // Response fields are registered on entry to DONE so they are valid
        // during the completion cycle and hold until the next completion.
        if (state_d == ST_DONE) begin
            rf_invalid_address_d = inv_d;
            if (inv_d) begin
                rf_read_data_d = '0;
            end else if (!is_wr_d) begin
                rf_read_data_d = rd_mux;
            end
        end

        rf_access_complete_d = (state_d == ST_DONE);
        rf_busy_d            = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_hmc) begin
        if (!res_n_hmc) begin
            state_q              <= ST_IDLE;
            cnt_q                <= '0;
            addr_q               <= '0;
            wdata_q              <= '0;
            is_wr_q              <= 1'b0;
            inv_q                <= 1'b0;
            regs_q               <= '0;
            rf_read_data_q       <= '0;
            rf_access_complete_q <= 1'b0;
            rf_invalid_address_q <= 1'b0;
            rf_busy_q            <= 1'b0;
        end else begin
            state_q              <= state_d;
            cnt_q                <= cnt_d;
            addr_q               <= addr_d;
            wdata_q              <= wdata_d;
            is_wr_q              <= is_wr_d;
            inv_q                <= inv_d;
            regs_q               <= regs_d;
            rf_read_data_q       <= rf_read_data_d;
            rf_access_complete_q <= rf_access_complete_d;
            rf_invalid_address_q <= rf_invalid_address_d;
            rf_busy_q            <= rf_busy_d;
        end
    end

    assign rf_read_data       = rf_read_data_q;
    assign rf_access_complete = rf_access_complete_q;
    assign rf_invalid_address = rf_invalid_address_q;
    assign rf_busy            = rf_busy_q;
    assign hw_reg_out         = regs_q;

endmodule

// File: tb/tb_hmc_rf_regbank.sv
// Bench for hmc_rf_regbank: one instance with ACCESS_LAT=1, one with ACCESS_LAT=3.
// Expected completions are queued by the driver and checked by a separate monitor.
// Register contents are compared against a small model after each access.
module tb_hmc_rf_regbank;
    localparam int AW = 4;
    localparam int DW = 64;
    localparam int NR = 12;

    typedef struct {
        int          cyc;
        logic [63:0] rd;
        logic        inv;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              res_n;
    logic [AW-1:0]     addr1, addr3;
    logic              rd1, wr1, rd3, wr3;
    logic [DW-1:0]     wd1, wd3;
    logic [DW-1:0]     rdata1, rdata3;
    logic              cmp1, cmp3, inv1, inv3, busy1, busy3;
    logic [NR*DW-1:0]  hw_ro_in, hw_set, regs1, regs3;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t q1[$];
    exp_t q3[$];
    logic [63:0] model [NR];
    logic [63:0] last_rd;

    hmc_rf_regbank #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .ACCESS_LAT(1),
                     .RO_MASK(12'h020), .W1C_MASK(12'h010)) u_dut1 (
        .clk_hmc(clk), .res_n_hmc(res_n), .rf_address(addr1), .rf_read_en(rd1),
        .rf_write_en(wr1), .rf_write_data(wd1), .rf_read_data(rdata1),
        .rf_access_complete(cmp1), .rf_invalid_address(inv1), .rf_busy(busy1),
        .hw_ro_in(hw_ro_in), .hw_set(hw_set), .hw_reg_out(regs1));

    hmc_rf_regbank #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .ACCESS_LAT(3),
                     .RO_MASK(12'h020), .W1C_MASK(12'h010)) u_dut3 (
        .clk_hmc(clk), .res_n_hmc(res_n), .rf_address(addr3), .rf_read_en(rd3),
        .rf_write_en(wr3), .rf_write_data(wd3), .rf_read_data(rdata3),
        .rf_access_complete(cmp3), .rf_invalid_address(inv3), .rf_busy(busy3),
        .hw_ro_in(hw_ro_in), .hw_set(hw_set), .hw_reg_out(regs3));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++)
            chk($sformatf("%s_reg%0d", tag, i), regs1[i*DW +: DW], model[i]);
    endtask

    // Monitor: every completion pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (cmp1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL dut1_unexpected_complete: got pulse expected none (cycle %0d)", cyc);
            end else begin
                e = q1.pop_front();
                chk("dut1_complete_cycle", 64'(cyc), 64'(e.cyc));
                chk("dut1_read_data", rdata1, e.rd);
                chk("dut1_invalid_flag", 64'(inv1), 64'(e.inv));
            end
        end
        if (cmp3) begin
            if (q3.size() == 0) begin
                total++; bad++;
                $display("FAIL dut3_unexpected_complete: got pulse expected none (cycle %0d)", cyc);
            end else begin
                e = q3.pop_front();
                chk("dut3_complete_cycle", 64'(cyc), 64'(e.cyc));
                chk("dut3_read_data", rdata3, e.rd);
                chk("dut3_invalid_flag", 64'(inv3), 64'(e.inv));
            end
        end
    end

    // One access: drive for a single cycle, queue the expected completion,
    // return on the first idle cycle after DONE (write effects visible).
    task automatic req(input int sel, input logic rd, input logic wr, input logic [3:0] a,
                       input logic [63:0] d, input logic [63:0] erd, input logic einv);
        exp_t e;
        int   lat;
        lat = (sel == 1) ? 1 : 3;
        @(negedge clk);
        if (sel == 1) begin rd1 = rd; wr1 = wr; addr1 = a; wd1 = d; end
        else          begin rd3 = rd; wr3 = wr; addr3 = a; wd3 = d; end
        e.cyc = cyc + 1 + lat;
        e.rd  = erd;
        e.inv = einv;
        if (sel == 1) q1.push_back(e); else q3.push_back(e);
        @(negedge clk);
        rd1 = 1'b0; wr1 = 1'b0; rd3 = 1'b0; wr3 = 1'b0;
        repeat (lat + 1) @(negedge clk);
    endtask

    initial begin
        exp_t e;
        res_n = 1'b0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wd1 = '0;
        rd3 = 1'b0; wr3 = 1'b0; addr3 = '0; wd3 = '0;
        hw_set = '0;
        hw_ro_in = '0;
        hw_ro_in[5*DW +: DW] = 64'hDEAD;
        hw_ro_in[2*DW +: DW] = 64'h5555;   // on an RW register, must be ignored
        for (int i = 0; i < NR; i++) model[i] = '0;
        last_rd = '0;

        repeat (3) @(negedge clk);
        chk("reset_read_data", rdata1, 64'h0);
        chk("reset_complete", 64'(cmp1), 64'h0);
        chk("reset_invalid", 64'(inv1), 64'h0);
        chk("reset_busy", 64'(busy1), 64'h0);
        check_regs("reset");
        res_n = 1'b1;

        // RW write then read back
        req(1, 1'b0, 1'b1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, last_rd, 1'b0);
        model[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        check_regs("rw_write");
        req(1, 1'b1, 1'b0, 4'd2, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        last_rd = 64'hFFFF_FFFF_FFFF_FFFF;

        // Out-of-range read and write
        req(1, 1'b1, 1'b0, 4'd13, 64'h0, 64'h0, 1'b1);
        last_rd = 64'h0;
        req(1, 1'b0, 1'b1, 4'd15, 64'h1234, 64'h0, 1'b1);
        check_regs("invalid_write");

        // Second write issued while busy is dropped
        @(negedge clk);
        wr1 = 1'b1; addr1 = 4'd1; wd1 = 64'hA5;
        e.cyc = cyc + 2; e.rd = last_rd; e.inv = 1'b0;
        q1.push_back(e);
        @(negedge clk);
        chk("busy_during_access", 64'(busy1), 64'h1);
        wd1 = 64'h5A;
        @(negedge clk);
        wr1 = 1'b0;
        @(negedge clk);
        model[1] = 64'hA5;
        check_regs("busy_drop");

        // W1C: hardware set, software clear, set-wins collision
        @(negedge clk);
        hw_set[4*DW +: DW] = 64'hF0;
        hw_set[1*DW +: DW] = 64'hFF00;     // on an RW register, must be ignored
        @(negedge clk);
        hw_set = '0;
        model[4] = 64'hF0;
        check_regs("w1c_set");
        req(1, 1'b0, 1'b1, 4'd4, 64'h30, last_rd, 1'b0);
        model[4] = 64'hC0;
        check_regs("w1c_clear");
        @(negedge clk);
        wr1 = 1'b1; addr1 = 4'd4; wd1 = 64'h40;
        e.cyc = cyc + 2; e.rd = last_rd; e.inv = 1'b0;
        q1.push_back(e);
        @(negedge clk);
        wr1 = 1'b0;
        @(negedge clk);                     // DONE cycle: set the same bit
        hw_set[4*DW +: DW] = 64'h40;
        @(negedge clk);
        hw_set = '0;
        check_regs("w1c_set_wins");
        req(1, 1'b1, 1'b0, 4'd4, 64'h0, 64'hC0, 1'b0);
        last_rd = 64'hC0;

        // RO: write ignored without error, read returns hardware value
        req(1, 1'b0, 1'b1, 4'd5, 64'h0, last_rd, 1'b0);
        check_regs("ro_write");
        req(1, 1'b1, 1'b0, 4'd5, 64'h0, 64'hDEAD, 1'b0);
        last_rd = 64'hDEAD;

        // Both enables together are rejected
        req(1, 1'b0, 1'b1, 4'd0, 64'h11, last_rd, 1'b0);
        model[0] = 64'h11;
        req(1, 1'b1, 1'b1, 4'd0, 64'h77, 64'h0, 1'b1);
        last_rd = 64'h0;
        check_regs("both_enables");

        // Longer latency instance
        req(3, 1'b0, 1'b1, 4'd2, 64'hABC, 64'h0, 1'b0);
        chk("dut3_reg2", regs3[2*DW +: DW], 64'hABC);
        req(3, 1'b1, 1'b0, 4'd2, 64'h0, 64'hABC, 1'b0);

        // Reset in WAIT abandons the access
        @(negedge clk);
        wr3 = 1'b1; addr3 = 4'd3; wd3 = 64'h99;
        @(negedge clk);
        wr3 = 1'b0;
        chk("dut3_busy_before_reset", 64'(busy3), 64'h1);
        res_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_read_data", rdata3, 64'h0);
        chk("rst_mid_complete", 64'(cmp3), 64'h0);
        chk("rst_mid_invalid", 64'(inv3), 64'h0);
        chk("rst_mid_busy", 64'(busy3), 64'h0);
        chk("rst_mid_regs_zero", 64'(regs3 == '0), 64'h1);
        res_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst_mid_reg3_unwritten", regs3[3*DW +: DW], 64'h0);

        chk("dut1_queue_drained", 64'(q1.size()), 64'h0);
        chk("dut3_queue_drained", 64'(q3.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
